gray_position_sampler: RTL and testbench

//   Captures a raw, asynchronous WIDTH-bit Gray-coded position word from an absolute encoder.

---
 rtl/gray_position_sampler.sv | 119 +++++++++++
 tb/tb_gray_position_sampler.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/gray_position_sampler.sv
// Absolute-encoder Gray sampler: synchronises, debounces and accepts Gray codes.
// Ports: clk, reset, gray_in -> gray, valid, update, jump_err, err_count.
module gray_position_sampler #(
  parameter int WIDTH         = 10,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] gray,
  output logic             valid,
  output logic             update,
  output logic             jump_err,
  output logic [7:0]       err_count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);

  localparam logic ST_INIT  = 1'b0;
  localparam logic ST_TRACK = 1'b1;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;
  logic             update_q, update_d;
  logic             jump_q, jump_d;
  logic [7:0]       err_q, err_d;
  logic             state_q, state_d;

  logic             qualified;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign qualified = (cnt_q == STABLE_C);
  assign diff      = cand_q ^ gray_q;
  // Clearing the lowest set bit leaves something only if >=2 bits differ.
  assign multi_bit = |(diff & (diff - WIDTH'(1)));

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    gray_d   = gray_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    jump_d   = 1'b0;
    err_d    = err_q;
    state_d  = state_q;

    // Filter runs independently; acceptance below uses the old cand_q,
    // so a change on the qualifying edge does not block acceptance.
    if (sync_out != cand_q) begin
      cand_d = sync_out;
      cnt_d  = CW'(1);
    end else if (cnt_q < STABLE_C) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (qualified) begin
      case (state_q)
        ST_INIT: begin
          gray_d   = cand_q;
          valid_d  = 1'b1;
          update_d = 1'b1;
          state_d  = ST_TRACK;
        end
        ST_TRACK: begin
          if (cand_q != gray_q) begin
            gray_d   = cand_q;
            update_d = 1'b1;
            if (multi_bit) begin
              jump_d = 1'b1;
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      gray_q   <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      jump_q   <= 1'b0;
      err_q    <= '0;
      state_q  <= ST_INIT;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      gray_q   <= gray_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      jump_q   <= jump_d;
      err_q    <= err_d;
      state_q  <= state_d;
    end
  end

  assign gray      = gray_q;
  assign valid     = valid_q;
  assign update    = update_q;
  assign jump_err  = jump_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gray_position_sampler.sv
// Scoreboard bench for gray_position_sampler.
// Stimulus pushes expected updates; a negedge monitor pops on update.
module tb_gray_position_sampler;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] gray_in;
  logic [9:0] gray;
  logic       valid, update, jump_err;
  logic [7:0] err_count;

  gray_position_sampler dut (
    .clk(clk), .reset(reset), .gray_in(gray_in),
    .gray(gray), .valid(valid), .update(update),
    .jump_err(jump_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] g;
    logic       j;
    logic [7:0] ec;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (update === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_update", {22'd0, gray}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("gray", {22'd0, gray}, {22'd0, e.g});
          chk("jump_err", {31'd0, jump_err}, {31'd0, e.j});
          chk("err_count", {24'd0, err_count}, {24'd0, e.ec});
          chk("valid", {31'd0, valid}, 32'd1);
          if (e.due >= 0) chk("latency", cyc, e.due);
        end
      end else if (jump_err !== 1'b0) begin
        chk("jump_without_update", {31'd0, jump_err}, 32'd0);
      end
    end
  end

  task automatic push(input logic [9:0] g, input logic j,
                      input logic [7:0] ec, input int due);
    exp_t e;
    e.g = g; e.j = j; e.ec = ec; e.due = due;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [9:0] v, input logic j,
                      input logic [7:0] ec, input int hold);
    gray_in = v;
    push(v, j, ec, cyc + 7);
    repeat (hold) @(negedge clk);
  endtask

  logic [7:0] ec_m;
  logic [9:0] v;

  initial begin
    reset   = 1'b1;
    gray_in = 10'h000;
    // 1: reset, outputs low, first code accepted after release
    repeat (3) begin
      @(negedge clk);
      chk("rst_gray", {22'd0, gray}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_update", {31'd0, update}, 32'd0);
      chk("rst_err", {24'd0, err_count}, 32'd0);
    end
    reset = 1'b0;
    push(10'h000, 1'b0, 8'd0, -1);
    repeat (12) @(negedge clk);
    chk("valid_after_init", {31'd0, valid}, 32'd1);

    // 2: single-bit step, 7-edge latency
    step(10'h001, 1'b0, 8'd0, 12);

    // 3: short glitch must be filtered
    gray_in = 10'h003;
    repeat (3) @(negedge clk);
    gray_in = 10'h001;
    repeat (12) @(negedge clk);
    chk("glitch_gray", {22'd0, gray}, 32'h001);

    // 4: multi-bit jump
    step(10'h0F0, 1'b1, 8'd1, 12);

    // 5: alternate full jumps, err_count saturates
    ec_m = 8'd1;
    for (int i = 0; i < 300; i++) begin
      v = (i % 2 == 0) ? 10'h3FF : 10'h000;
      if (ec_m != 8'hFF) ec_m = ec_m + 8'd1;
      step(v, 1'b1, ec_m, 6);
    end
    repeat (10) @(negedge clk);
    chk("err_saturated", {24'd0, err_count}, 32'd255);

    // wrap-around MSB step is a legal single-bit step
    step(10'h200, 1'b0, 8'd255, 12);
    step(10'h000, 1'b0, 8'd255, 12);

    // 6: reset while a pending code has cnt=2
    gray_in = 10'h155;
    repeat (4) @(negedge clk);
    reset   = 1'b1;
    gray_in = 10'h000;
    @(negedge clk);
    chk("r6_valid", {31'd0, valid}, 32'd0);
    chk("r6_err", {24'd0, err_count}, 32'd0);
    chk("r6_gray", {22'd0, gray}, 32'd0);
    chk("r6_update", {31'd0, update}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    push(10'h000, 1'b0, 8'd0, -1);
    repeat (12) @(negedge clk);
    chk("r6_valid_again", {31'd0, valid}, 32'd1);
    chk("r6_gray_again", {22'd0, gray}, 32'd0);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
